// File: rtl/wb_register_file.sv
// Writeback stage of the 5-stage MIPS pipeline: writeback mux, 32x32 register file, retired-write counter.
// Optional build macro WB_BYPASS_EN: write-first bypass from the writeback port to both read ports.
module wb_register_file #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5,
    parameter int RA_INDEX   = 31
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] in_PC,
    input  logic                  in_Ctrl_Jal,
    input  logic                  in_Ctrl_RegWrite,
    input  logic                  in_Ctrl_MemToReg,
    input  logic [DATA_WIDTH-1:0] in_RAM_Read_Data,
    input  logic [DATA_WIDTH-1:0] in_ALU_Result,
    input  logic [ADDR_WIDTH-1:0] in_Write_Register,
    input  logic [ADDR_WIDTH-1:0] in_Read_Reg1,
    input  logic [ADDR_WIDTH-1:0] in_Read_Reg2,
    output logic [DATA_WIDTH-1:0] out_Read_Data1,
    output logic [DATA_WIDTH-1:0] out_Read_Data2,
    output logic [DATA_WIDTH-1:0] out_WB_Data,
    output logic [31:0]           out_Write_Count
);

    localparam int DEPTH = 1 << ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] regs [DEPTH];
    logic [ADDR_WIDTH-1:0] dest;
    logic                  we;

    always_comb begin
        if (in_Ctrl_Jal) begin
            out_WB_Data = in_PC;
        end else if (in_Ctrl_MemToReg) begin
            out_WB_Data = in_RAM_Read_Data;
        end else begin
            out_WB_Data = in_ALU_Result;
        end
    end

    assign dest = in_Ctrl_Jal ? ADDR_WIDTH'(RA_INDEX) : in_Write_Register;
    // Register 0 is hardwired: a write aimed at it neither lands nor counts.
    assign we   = (in_Ctrl_RegWrite | in_Ctrl_Jal) & (dest != '0);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs[i] <= '0;
            end
            out_Write_Count <= '0;
        end else if (we) begin
            regs[dest]      <= out_WB_Data;
            out_Write_Count <= out_Write_Count + 32'd1;
        end
    end

    always_comb begin
        out_Read_Data1 = regs[in_Read_Reg1];
        out_Read_Data2 = regs[in_Read_Reg2];
`ifdef WB_BYPASS_EN
        // we implies dest != 0, so the bypass can never expose data on register 0.
        if (we && (in_Read_Reg1 == dest)) begin
            out_Read_Data1 = out_WB_Data;
        end
        if (we && (in_Read_Reg2 == dest)) begin
            out_Read_Data2 = out_WB_Data;
        end
`endif
        if (in_Read_Reg1 == '0) begin
            out_Read_Data1 = '0;
        end
        if (in_Read_Reg2 == '0) begin
            out_Read_Data2 = '0;
        end
    end

endmodule

// File: tb/tb_wb_register_file.sv
// Directed self-checking bench for wb_register_file; expectations adapt to the WB_BYPASS_EN build.
module tb_wb_register_file;

  logic        clk;
  logic        reset;
  logic [31:0] in_PC;
  logic        in_Ctrl_Jal;
  logic        in_Ctrl_RegWrite;
  logic        in_Ctrl_MemToReg;
  logic [31:0] in_RAM_Read_Data;
  logic [31:0] in_ALU_Result;
  logic [4:0]  in_Write_Register;
  logic [4:0]  in_Read_Reg1;
  logic [4:0]  in_Read_Reg2;
  logic [31:0] out_Read_Data1;
  logic [31:0] out_Read_Data2;
  logic [31:0] out_WB_Data;
  logic [31:0] out_Write_Count;

  int n_compared;
  int n_mismatched;
  logic [31:0] exp_q[$];
  logic        bypass;

  wb_register_file dut (
    .clk               (clk),
    .reset             (reset),
    .in_PC             (in_PC),
    .in_Ctrl_Jal       (in_Ctrl_Jal),
    .in_Ctrl_RegWrite  (in_Ctrl_RegWrite),
    .in_Ctrl_MemToReg  (in_Ctrl_MemToReg),
    .in_RAM_Read_Data  (in_RAM_Read_Data),
    .in_ALU_Result     (in_ALU_Result),
    .in_Write_Register (in_Write_Register),
    .in_Read_Reg1      (in_Read_Reg1),
    .in_Read_Reg2      (in_Read_Reg2),
    .out_Read_Data1    (out_Read_Data1),
    .out_Read_Data2    (out_Read_Data2),
    .out_WB_Data       (out_WB_Data),
    .out_Write_Count   (out_Write_Count)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // checking
  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_compared++;
    if (got !== exp) begin
      n_mismatched++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // drivers
  task automatic drive_idle();
    in_PC             = 32'h0;
    in_Ctrl_Jal       = 1'b0;
    in_Ctrl_RegWrite  = 1'b0;
    in_Ctrl_MemToReg  = 1'b0;
    in_RAM_Read_Data  = 32'h0;
    in_ALU_Result     = 32'h0;
    in_Write_Register = 5'd0;
  endtask

  task automatic drive_write(input logic jal, input logic regwrite, input logic memtoreg,
                             input logic [31:0] pc, input logic [31:0] ram,
                             input logic [31:0] alu, input logic [4:0] wr);
    in_PC             = pc;
    in_Ctrl_Jal       = jal;
    in_Ctrl_RegWrite  = regwrite;
    in_Ctrl_MemToReg  = memtoreg;
    in_RAM_Read_Data  = ram;
    in_ALU_Result     = alu;
    in_Write_Register = wr;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic read_regs(input logic [4:0] r1, input logic [4:0] r2);
    in_Read_Reg1 = r1;
    in_Read_Reg2 = r2;
    #1;
  endtask

  initial begin
    n_compared   = 0;
    n_mismatched = 0;
`ifdef WB_BYPASS_EN
    bypass = 1'b1;
`else
    bypass = 1'b0;
`endif
    reset = 1'b0;
    drive_idle();
    in_Read_Reg1 = 5'd0;
    in_Read_Reg2 = 5'd0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    #1;

    // reset state: every register reads zero on both ports
    for (int i = 0; i < 32; i++) begin
      exp_q.push_back(32'h0);
    end
    for (int i = 0; i < 32; i++) begin
      logic [31:0] e;
      read_regs(5'(i), 5'(31 - i));
      e = exp_q.pop_front();
      check_eq($sformatf("reset_rd1_r%0d", i), out_Read_Data1, e);
      check_eq($sformatf("reset_rd2_r%0d", 31 - i), out_Read_Data2, e);
    end
    check_eq("reset_count", out_Write_Count, 32'd0);

    // ALU writeback
    drive_write(1'b0, 1'b1, 1'b0, 32'h1111_1111, 32'h2222_2222, 32'h1234_5678, 5'd8);
    #1;
    check_eq("alu_wb_data", out_WB_Data, 32'h1234_5678);
    tick();
    drive_idle();
    read_regs(5'd8, 5'd9);
    check_eq("alu_reg8", out_Read_Data1, 32'h1234_5678);
    check_eq("alu_count", out_Write_Count, 32'd1);

    // RAM writeback
    drive_write(1'b0, 1'b1, 1'b1, 32'h1111_1111, 32'hDEAD_BEEF, 32'h5555_5555, 5'd9);
    #1;
    check_eq("mem_wb_data", out_WB_Data, 32'hDEAD_BEEF);
    tick();
    drive_idle();
    read_regs(5'd8, 5'd9);
    check_eq("mem_reg9", out_Read_Data2, 32'hDEAD_BEEF);
    check_eq("mem_reg8_kept", out_Read_Data1, 32'h1234_5678);
    check_eq("mem_count", out_Write_Count, 32'd2);

    // Jal link overrides dest and data
    drive_write(1'b1, 1'b0, 1'b1, 32'h0040_0024, 32'h6666_6666, 32'h7777_7777, 5'd5);
    #1;
    check_eq("jal_wb_data", out_WB_Data, 32'h0040_0024);
    tick();
    drive_idle();
    read_regs(5'd31, 5'd5);
    check_eq("jal_reg31", out_Read_Data1, 32'h0040_0024);
    check_eq("jal_reg5_untouched", out_Read_Data2, 32'h0);
    check_eq("jal_count", out_Write_Count, 32'd3);

    // register 0 guard
    drive_write(1'b0, 1'b1, 1'b0, 32'h0, 32'h0, 32'hFFFF_FFFF, 5'd0);
    read_regs(5'd0, 5'd0);
    check_eq("r0_pre_rd1", out_Read_Data1, 32'h0);
    check_eq("r0_pre_rd2", out_Read_Data2, 32'h0);
    tick();
    drive_idle();
    read_regs(5'd0, 5'd0);
    check_eq("r0_post_rd1", out_Read_Data1, 32'h0);
    check_eq("r0_post_rd2", out_Read_Data2, 32'h0);
    check_eq("r0_count", out_Write_Count, 32'd3);

    // same-cycle read and write of reg10
    drive_write(1'b0, 1'b1, 1'b0, 32'h0, 32'h0, 32'hA5A5_A5A5, 5'd10);
    read_regs(5'd8, 5'd10);
    check_eq("rw_pre_rd2", out_Read_Data2, bypass ? 32'hA5A5_A5A5 : 32'h0);
    check_eq("rw_pre_rd1_other", out_Read_Data1, 32'h1234_5678);
    read_regs(5'd10, 5'd8);
    check_eq("rw_pre_rd1", out_Read_Data1, bypass ? 32'hA5A5_A5A5 : 32'h0);
    tick();
    drive_idle();
    read_regs(5'd8, 5'd10);
    check_eq("rw_post_rd2", out_Read_Data2, 32'hA5A5_A5A5);
    check_eq("rw_count", out_Write_Count, 32'd4);

    // matching index without a write request must not bypass
    drive_write(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h1111_2222, 5'd10);
    read_regs(5'd10, 5'd10);
    check_eq("nowe_rd1", out_Read_Data1, 32'hA5A5_A5A5);
    check_eq("nowe_rd2", out_Read_Data2, 32'hA5A5_A5A5);
    tick();
    read_regs(5'd10, 5'd10);
    check_eq("nowe_post_rd1", out_Read_Data1, 32'hA5A5_A5A5);
    check_eq("nowe_count", out_Write_Count, 32'd4);
    drive_idle();

    // counter wrap
    force dut.out_Write_Count = 32'hFFFF_FFFF;
    #1;
    release dut.out_Write_Count;
    #1;
    check_eq("wrap_preload", out_Write_Count, 32'hFFFF_FFFF);
    drive_write(1'b0, 1'b1, 1'b0, 32'h0, 32'h0, 32'h0000_0077, 5'd11);
    tick();
    drive_idle();
    read_regs(5'd11, 5'd0);
    check_eq("wrap_count", out_Write_Count, 32'h0);
    check_eq("wrap_reg11", out_Read_Data1, 32'h0000_0077);

    // mid-burst asynchronous reset
    drive_write(1'b0, 1'b1, 1'b0, 32'h0, 32'h0, 32'hCAFE_0001, 5'd12);
    tick();
    read_regs(5'd12, 5'd13);
    check_eq("burst_reg12", out_Read_Data1, 32'hCAFE_0001);
    check_eq("burst_count", out_Write_Count, 32'd1);
    drive_write(1'b0, 1'b1, 1'b0, 32'h0, 32'h0, 32'hCAFE_0002, 5'd13);
    reset = 1'b0;
    read_regs(5'd12, 5'd8);
    check_eq("async_rst_reg12", out_Read_Data1, 32'h0);
    check_eq("async_rst_reg8", out_Read_Data2, 32'h0);
    check_eq("async_rst_count", out_Write_Count, 32'h0);
    tick();
    read_regs(5'd13, 5'd12);
    check_eq("rst_edge_reg13", out_Read_Data1, 32'h0);
    check_eq("rst_edge_count", out_Write_Count, 32'h0);
    @(negedge clk);
    reset = 1'b1;
    tick();
    drive_idle();
    read_regs(5'd13, 5'd12);
    check_eq("post_rst_reg13", out_Read_Data1, 32'hCAFE_0002);
    check_eq("post_rst_reg12", out_Read_Data2, 32'h0);
    check_eq("post_rst_count", out_Write_Count, 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
